// File: rtl/dlsc_vga_input_pkg.sv
// Shared widths, types and the pixel lane-packing helper for the VGA capture block.
//   pos_t  : 2-bit byte-lane selector
//   byte_t : one 8-bit colour channel
//   word_t : 32-bit packed pixel word
package dlsc_vga_input_pkg;

   localparam int unsigned POS_W  = 2;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;

   typedef logic [POS_W-1:0]  pos_t;
   typedef logic [BYTE_W-1:0] byte_t;
   typedef logic [WORD_W-1:0] word_t;

   // Channels land in lane order r, g, b, a; a later channel overwrites an earlier one.
   function automatic word_t pack_pixel(
      input byte_t r, input byte_t g, input byte_t b, input byte_t a,
      input pos_t  pos_r, input pos_t pos_g, input pos_t pos_b, input pos_t pos_a
   );
      word_t w;
      w = '0;
      w[int'(pos_r)*BYTE_W +: BYTE_W] = r;
      w[int'(pos_g)*BYTE_W +: BYTE_W] = g;
      w[int'(pos_b)*BYTE_W +: BYTE_W] = b;
      w[int'(pos_a)*BYTE_W +: BYTE_W] = a;
      return w;
   endfunction

endpackage

// File: rtl/dlsc_vga_input_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed pixel words.
//   push/push_data : write when not full (full is judged before any same-cycle pop)
//   pop/pop_data   : pop_data is valid whenever empty is low; pop consumes it
//   full/empty     : occupancy flags derived from the registered count
module dlsc_vga_input_fifo
   import dlsc_vga_input_pkg::*;
#(
   parameter int unsigned FIFO_ADDR = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  word_t push_data,
   input  logic  pop,
   output word_t pop_data,
   output logic  full,
   output logic  empty
);

   localparam int unsigned DEPTH = 1 << FIFO_ADDR;
   localparam int unsigned CNT_W = FIFO_ADDR + 1;

   word_t                mem [DEPTH];
   logic [FIFO_ADDR-1:0] wr_ptr;
   logic [FIFO_ADDR-1:0] rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 do_push;
   logic                 do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + FIFO_ADDR'(1);
         if (do_pop)  rd_ptr <= rd_ptr + FIFO_ADDR'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dlsc_vga_input.sv
// Video capture: samples a parallel pixel bus, packs accepted pixels into 32-bit
// words, buffers them in an FWFT FIFO and reports frame geometry.
//   clk, rst                    : clock, synchronous active-high reset
//   frame_start/frame_done      : one-cycle frame boundary pulses
//   overflow                    : sticky pixel-drop flag, cleared at frame end
//   size_error                  : pulses with frame_done when geometry mismatched
//   meas_width/meas_height      : last completed line width / frame height
//   hdisp/vdisp, pos_*          : expected geometry, byte lane per channel
//   px_*                        : incoming video bus
//   out_ready/out_valid/out_data: output stream
module dlsc_vga_input
   import dlsc_vga_input_pkg::*;
#(
   parameter int unsigned XBITS     = 12,
   parameter int unsigned YBITS     = 12,
   parameter int unsigned FIFO_ADDR = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic             frame_start,
   output logic             frame_done,
   output logic             overflow,
   output logic             size_error,
   output logic [XBITS-1:0] meas_width,
   output logic [YBITS-1:0] meas_height,
   input  logic [XBITS-1:0] hdisp,
   input  logic [YBITS-1:0] vdisp,
   input  logic [1:0]       pos_r,
   input  logic [1:0]       pos_g,
   input  logic [1:0]       pos_b,
   input  logic [1:0]       pos_a,
   input  logic             px_en,
   input  logic             px_vsync,
   input  logic             px_hsync,
   input  logic             px_frame_valid,
   input  logic             px_line_valid,
   input  logic             px_valid,
   input  logic [7:0]       px_r,
   input  logic [7:0]       px_g,
   input  logic [7:0]       px_b,
   input  logic [7:0]       px_a,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [31:0]      out_data
);

   // Input register; deliberately not reset so that a frame already in
   // progress when rst releases is seen as level-high, not as a rising edge.
   logic       fv_q, prev_fv, lv_q, v_q, prev_lvf;
   logic [1:0] syncs_unused_q;
   byte_t      r_q, g_q, b_q, a_q;

   always_ff @(posedge clk) begin
      fv_q           <= px_en && px_frame_valid;
      prev_fv        <= fv_q;
      lv_q           <= px_line_valid;
      v_q            <= px_valid;
      prev_lvf       <= fv_q && lv_q;
      syncs_unused_q <= {px_vsync, px_hsync};
      r_q            <= px_r;
      g_q            <= px_g;
      b_q            <= px_b;
      a_q            <= px_a;
   end

   logic             armed;
   logic [XBITS-1:0] x;
   logic [YBITS-1:0] y;
   logic             line_err;

   logic             rise, fall, armed_c, lvf, line_end, qual;
   logic [XBITS-1:0] x_nxt;
   logic [YBITS-1:0] y_nxt;
   logic             err_nxt;
   logic             fifo_full, fifo_empty, fifo_push;
   word_t            fifo_rdata;

   assign rise     = fv_q && !prev_fv;
   assign fall     = !fv_q && prev_fv && armed;
   assign armed_c  = armed || rise;
   assign lvf      = fv_q && lv_q;
   assign line_end = prev_lvf && !lvf && armed;
   assign qual     = lvf && v_q && armed_c;

   // Next-state of the geometry counters; saturate rather than wrap.
   always_comb begin
      x_nxt   = x;
      y_nxt   = y;
      err_nxt = line_err;
      if (rise) begin
         x_nxt   = '0;
         y_nxt   = '0;
         err_nxt = 1'b0;
      end
      if (line_end) begin
         x_nxt = '0;
         if (y != '1)     y_nxt   = y + YBITS'(1);
         if (x != hdisp)  err_nxt = 1'b1;
      end else if (qual && (x_nxt != '1)) begin
         x_nxt = x_nxt + XBITS'(1);
      end
   end

   // Frame tracking, status pulses and measurement latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed       <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_err    <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         size_error  <= 1'b0;
         overflow    <= 1'b0;
         meas_width  <= '0;
         meas_height <= '0;
      end else begin
         armed       <= armed_c;
         x           <= x_nxt;
         y           <= y_nxt;
         line_err    <= err_nxt;
         frame_start <= rise;
         frame_done  <= fall;
         size_error  <= fall && (err_nxt || (y_nxt != vdisp));
         if (line_end) meas_width  <= x;
         if (fall)     meas_height <= y_nxt;
         // Once a pixel is lost the rest of the frame is dropped too.
         if (fall)                        overflow <= 1'b0;
         else if (qual && fifo_full)      overflow <= 1'b1;
      end
   end

   assign fifo_push = qual && !fifo_full && !overflow;

   dlsc_vga_input_fifo #(
      .FIFO_ADDR (FIFO_ADDR)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (pack_pixel(r_q, g_q, b_q, a_q, pos_r, pos_g, pos_b, pos_a)),
      .pop       (out_ready),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_rdata;

endmodule

// File: tb/tb_dlsc_vga_input.sv
module tb_dlsc_vga_input;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start, frame_done, overflow, size_error;
   logic [11:0] meas_width, meas_height, hdisp, vdisp;
   logic [1:0]  pos_r, pos_g, pos_b, pos_a;
   logic        px_en, px_vsync, px_hsync, px_frame_valid, px_line_valid, px_valid;
   logic [7:0]  px_r, px_g, px_b, px_a;
   logic        out_ready, out_valid;
   logic [31:0] out_data;

   always #5 clk = ~clk;

   dlsc_vga_input #(.XBITS(12), .YBITS(12), .FIFO_ADDR(4)) dut (
      .clk(clk), .rst(rst),
      .frame_start(frame_start), .frame_done(frame_done), .overflow(overflow),
      .size_error(size_error), .meas_width(meas_width), .meas_height(meas_height),
      .hdisp(hdisp), .vdisp(vdisp),
      .pos_r(pos_r), .pos_g(pos_g), .pos_b(pos_b), .pos_a(pos_a),
      .px_en(px_en), .px_vsync(px_vsync), .px_hsync(px_hsync),
      .px_frame_valid(px_frame_valid), .px_line_valid(px_line_valid), .px_valid(px_valid),
      .px_r(px_r), .px_g(px_g), .px_b(px_b), .px_a(px_a),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Ready mode: 0 = hold low, 1 = hold high, 2 = random (75% high).
   int ready_mode = 1;
   initial out_ready = 1'b1;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Output monitor sampling on the falling edge.
   logic [31:0] words[$];
   int n_start, n_done, n_err;
   logic ovf_seen;
   always @(negedge clk) begin
      if (out_valid && out_ready) words.push_back(out_data);
      if (frame_start) n_start++;
      if (frame_done)  n_done++;
      if (size_error)  n_err++;
      if (overflow)    ovf_seen = 1'b1;
   end

   task automatic clear_mon();
      @(posedge clk); #2;
      words.delete();
      n_start = 0; n_done = 0; n_err = 0; ovf_seen = 1'b0;
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Pixel source: fixed channels, or a sequence number when seq_mode is set.
   logic       seq_mode;
   logic [7:0] cur_r, cur_g, cur_b, cur_a;
   int         pix_idx;

   function automatic logic [31:0] seq_word(input int i);
      logic [15:0] v;
      v = 16'(i);
      return {8'hA5, 8'h5A, v};
   endfunction

   task automatic frame_begin();
      px_frame_valid = 1'b1; px_line_valid = 1'b0; px_valid = 1'b0;
      pix_idx = 0;
      tick(2);
   endtask

   task automatic frame_end();
      px_frame_valid = 1'b0; px_line_valid = 1'b0; px_valid = 1'b0;
      tick(4);
   endtask

   task automatic send_lines(input int w, input int h, input int gap);
      for (int l = 0; l < h; l++) begin
         for (int p = 0; p < w; p++) begin
            for (int g = 0; g < gap; g++) begin
               px_line_valid = 1'b1; px_valid = 1'b0; tick();
            end
            px_line_valid = 1'b1; px_valid = 1'b1;
            if (seq_mode) begin
               px_r = 8'(pix_idx); px_g = 8'(pix_idx >> 8); px_b = 8'h5A; px_a = 8'hA5;
            end else begin
               px_r = cur_r; px_g = cur_g; px_b = cur_b; px_a = cur_a;
            end
            pix_idx++;
            tick();
         end
         px_line_valid = 1'b0; px_valid = 1'b0;
         tick(2);
      end
   endtask

   task automatic wait_words(input int n);
      for (int i = 0; i < 3000 && words.size() < n; i++) tick();
      tick(3);
   endtask

   typedef struct {
      string       name;
      logic [11:0] hdisp, vdisp;
      logic [1:0]  pr, pg, pb, pa;
      int          w, h;
      logic [7:0]  r, g, b, a;
      logic [31:0] exp_word;
      logic        exp_err;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{"nominal",  12'd4, 12'd2, 2'd0, 2'd1, 2'd2, 2'd3, 4, 2,
                  8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211, 1'b0};
      vecs[1] = '{"remap",    12'd4, 12'd2, 2'd3, 2'd3, 2'd0, 2'd1, 4, 2,
                  8'h11, 8'h22, 8'h33, 8'h44, 32'h22004433, 1'b0};
      vecs[2] = '{"sizeerr",  12'd4, 12'd2, 2'd0, 2'd1, 2'd2, 2'd3, 3, 3,
                  8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211, 1'b1};
      vecs[3] = '{"alllane0", 12'd2, 12'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2, 1,
                  8'h11, 8'h22, 8'h33, 8'h44, 32'h00000044, 1'b0};

      rst = 1'b1;
      hdisp = 12'd4; vdisp = 12'd2;
      pos_r = 2'd0; pos_g = 2'd1; pos_b = 2'd2; pos_a = 2'd3;
      px_en = 1'b1; px_vsync = 1'b0; px_hsync = 1'b0;
      px_frame_valid = 1'b0; px_line_valid = 1'b0; px_valid = 1'b0;
      px_r = '0; px_g = '0; px_b = '0; px_a = '0;
      seq_mode = 1'b0; cur_r = '0; cur_g = '0; cur_b = '0; cur_a = '0;
      pix_idx = 0;
      n_start = 0; n_done = 0; n_err = 0; ovf_seen = 1'b0;
      tick(5);
      rst = 1'b0;
      tick(2);
      @(negedge clk);
      chk("reset out_valid",   32'(out_valid), 0);
      chk("reset overflow",    32'(overflow), 0);
      chk("reset meas_width",  32'(meas_width), 0);
      chk("reset meas_height", 32'(meas_height), 0);
      chk("reset frame_start", 32'(frame_start), 0);

      // Table-driven single frames, full-rate drain.
      ready_mode = 1;
      foreach (vecs[k]) begin
         clear_mon();
         hdisp = vecs[k].hdisp; vdisp = vecs[k].vdisp;
         pos_r = vecs[k].pr; pos_g = vecs[k].pg; pos_b = vecs[k].pb; pos_a = vecs[k].pa;
         cur_r = vecs[k].r; cur_g = vecs[k].g; cur_b = vecs[k].b; cur_a = vecs[k].a;
         frame_begin();
         send_lines(vecs[k].w, vecs[k].h, 0);
         frame_end();
         wait_words(vecs[k].w * vecs[k].h);
         chk({vecs[k].name, " word count"}, 32'(words.size()), 32'(vecs[k].w * vecs[k].h));
         foreach (words[i]) chk({vecs[k].name, " word"}, words[i], vecs[k].exp_word);
         chk({vecs[k].name, " frame_start"}, 32'(n_start), 1);
         chk({vecs[k].name, " frame_done"},  32'(n_done), 1);
         chk({vecs[k].name, " size_error"},  32'(n_err), 32'(vecs[k].exp_err));
         chk({vecs[k].name, " meas_width"},  32'(meas_width), 32'(vecs[k].w));
         chk({vecs[k].name, " meas_height"}, 32'(meas_height), 32'(vecs[k].h));
         chk({vecs[k].name, " overflow"},    32'(ovf_seen), 0);
      end

      pos_r = 2'd0; pos_g = 2'd1; pos_b = 2'd2; pos_a = 2'd3;
      seq_mode = 1'b1;

      // Latency: one pixel into an empty FIFO appears two edges after sampling.
      clear_mon();
      ready_mode = 0; hdisp = 12'd1; vdisp = 12'd1;
      frame_begin();
      px_line_valid = 1'b1; px_valid = 1'b1;
      px_r = 8'h00; px_g = 8'h00; px_b = 8'h5A; px_a = 8'hA5;
      tick();
      px_valid = 1'b0;
      @(negedge clk);
      chk("latency edge1 out_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("latency edge2 out_valid", 32'(out_valid), 1);
      chk("latency edge2 out_data",  out_data, seq_word(0));
      tick();
      px_line_valid = 1'b0; tick(2);
      frame_end();
      ready_mode = 1;
      wait_words(1);
      chk("latency words", 32'(words.size()), 1);

      // Exactly full FIFO: no overflow.
      clear_mon();
      ready_mode = 0; hdisp = 12'd16; vdisp = 12'd1;
      frame_begin(); send_lines(16, 1, 0); frame_end();
      chk("fill16 overflow", 32'(ovf_seen), 0);
      ready_mode = 1; wait_words(16);
      chk("fill16 words", 32'(words.size()), 16);

      // Overflow: 20 pixels with the output stalled.
      clear_mon();
      ready_mode = 0; hdisp = 12'd20; vdisp = 12'd1;
      frame_begin(); send_lines(20, 1, 0);
      @(negedge clk);
      chk("ovf set before frame end", 32'(overflow), 1);
      ready_mode = 1;
      tick(20);
      chk("ovf still set while draining", 32'(overflow), 1);
      frame_end();
      @(negedge clk);
      chk("ovf cleared after frame_done", 32'(overflow), 0);
      chk("ovf frame_done", 32'(n_done), 1);
      wait_words(16);
      chk("ovf words stored", 32'(words.size()), 16);
      for (int i = 0; i < words.size(); i++) chk("ovf word order", words[i], seq_word(i));

      // Next frame after an overflow captures normally.
      clear_mon();
      hdisp = 12'd4; vdisp = 12'd2;
      frame_begin(); send_lines(4, 2, 0); frame_end();
      wait_words(8);
      chk("post-ovf words", 32'(words.size()), 8);
      chk("post-ovf size_error", 32'(n_err), 0);
      chk("post-ovf overflow", 32'(ovf_seen), 0);

      // Reset released mid-frame: that frame is ignored entirely.
      rst = 1'b1; tick(2);
      frame_begin(); send_lines(4, 1, 0);
      rst = 1'b0;
      clear_mon();
      send_lines(4, 1, 0);
      frame_end();
      tick(5);
      chk("rst-mid words", 32'(words.size()), 0);
      chk("rst-mid frame_start", 32'(n_start), 0);
      chk("rst-mid frame_done", 32'(n_done), 0);
      clear_mon();
      hdisp = 12'd2; vdisp = 12'd1;
      frame_begin(); send_lines(2, 1, 0); frame_end();
      wait_words(2);
      chk("rst-next frame_start", 32'(n_start), 1);
      chk("rst-next words", 32'(words.size()), 2);
      chk("rst-next size_error", 32'(n_err), 0);

      // px_en drop mid-line acts as frame end.
      clear_mon();
      hdisp = 12'd4; vdisp = 12'd2;
      frame_begin(); send_lines(2, 1, 0);
      px_line_valid = 1'b1; px_valid = 1'b0; px_en = 1'b0; tick(3);
      px_frame_valid = 1'b0; px_line_valid = 1'b0; tick();
      px_en = 1'b1; tick(4);
      wait_words(2);
      chk("en-drop frame_done", 32'(n_done), 1);
      chk("en-drop size_error", 32'(n_err), 1);
      chk("en-drop words", 32'(words.size()), 2);

      // Random backpressure over a 64x4 frame with sparse pixels.
      clear_mon();
      ready_mode = 2; hdisp = 12'd64; vdisp = 12'd4;
      frame_begin(); send_lines(64, 4, 2); frame_end();
      wait_words(256);
      ready_mode = 1;
      chk("bp words", 32'(words.size()), 256);
      for (int i = 0; i < words.size(); i++) chk("bp word order", words[i], seq_word(i));
      chk("bp overflow", 32'(ovf_seen), 0);
      chk("bp size_error", 32'(n_err), 0);
      chk("bp meas_width", 32'(meas_width), 64);
      chk("bp meas_height", 32'(meas_height), 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
